// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between a fifo and the serial drain stage.
// master: the drain (issues pops); slave: the fifo (supplies empty flag and data).
interface fifo_uart_tx_if #(
    parameter int WIDTH = 4
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_read;

    modport master (input fifo_empty, input fifo_data, output fifo_read);
    modport slave  (output fifo_empty, output fifo_data, input fifo_read);
endinterface

// File: rtl/fifo_uart_tx.sv
// Fifo drain stage: pops one word at a time and sends it as an LSB-first serial frame.
// Build option: define FIFO_UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module fifo_uart_tx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    fifo_uart_tx_if.master  fifo,
    output logic            tx,
    output logic            busy,
    output logic            frame_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;
`endif

    state_t           state, state_n;
    logic [CW-1:0]    clk_cnt, clk_cnt_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shift_reg, shift_n;
    logic             tx_n, read_n, busy_n, done_n;
    logic             bit_end;

    assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            clk_cnt        <= '0;
            bit_cnt        <= '0;
            shift_reg      <= '0;
            tx             <= 1'b1;
            fifo.fifo_read <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            state          <= state_n;
            clk_cnt        <= clk_cnt_n;
            bit_cnt        <= bit_cnt_n;
            shift_reg      <= shift_n;
            tx             <= tx_n;
            fifo.fifo_read <= read_n;
            busy           <= busy_n;
            frame_done     <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_cnt_n = bit_cnt;
        shift_n   = shift_reg;
        tx_n      = tx;
        read_n    = 1'b0;
        busy_n    = busy;
        done_n    = 1'b0;
        // Serial bit states share one clock counter that wraps every bit period.
        if (state != IDLE && state != POP && state != LOAD)
            clk_cnt_n = bit_end ? '0 : clk_cnt + 1'b1;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (!fifo.fifo_empty) begin
                    state_n = POP;
                    read_n  = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            POP: state_n = LOAD;
            LOAD: begin
                shift_n   = fifo.fifo_data;
                tx_n      = 1'b0;
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                state_n   = START;
            end
            START: if (bit_end) begin
                state_n = DATA;
                tx_n    = shift_reg[0];
            end
            DATA: if (bit_end) begin
                if (bit_cnt == BW'(WIDTH - 1)) begin
                    bit_cnt_n = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                    state_n   = PARITY;
                    tx_n      = ^shift_reg;
`else
                    state_n   = STOP;
                    tx_n      = 1'b1;
`endif
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    tx_n      = shift_reg[bit_cnt + 1'b1];
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
                state_n = STOP;
                tx_n    = 1'b1;
            end
`endif
            STOP: if (bit_end) begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
                done_n  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a small fifo model feeds words; expected line activity comes from a frame-level model.
module tb_fifo_uart_tx;
    localparam int W    = 4;
    localparam int C    = 4;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR  = 1;
`else
    localparam int PAR  = 0;
`endif
    localparam int NB   = W + 2 + PAR;
    localparam int P    = 3 + NB * C;
    localparam int MAXN = 512;

    logic clk = 1'b0;
    logic rst;
    logic tx, busy, frame_done;
    logic hold_empty = 1'b0;
    int   wr_i = 0;
    int   rd_i = 0;
    logic [W-1:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    logic [W-1:0] sw [0:7];
    int           sa [0:7];
    int           snw;
    logic [3:0]   exp_v  [0:MAXN-1];
    logic         obs_tx [0:MAXN-1];
    logic         obs_dn [0:MAXN-1];
    int           n_reads;

    always #3 clk = ~clk;

    fifo_uart_tx_if #(.WIDTH(W)) bus ();

    fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst(rst), .fifo(bus),
        .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    // Fifo model: data appears the cycle after a pop strobe.
    assign bus.fifo_empty = hold_empty || (wr_i == rd_i);
    always @(posedge clk) begin
        if (bus.fifo_read === 1'b1) begin
            bus.fifo_data <= mem[rd_i[7:0]];
            rd_i          <= rd_i + 1;
        end
    end

    task automatic push(input logic [W-1:0] w);
        mem[wr_i[7:0]] = w;
        wr_i = wr_i + 1;
    endtask

    // Runs sw/sa/snw from a negedge; word j is pushed just before edge sa[j] (-1 = already queued).
    task automatic run_stream(input string name);
        int kp, last, n, b, arr;
        logic bitv;
        logic [3:0] obs;
        for (int i = 0; i < MAXN; i++) exp_v[i] = 4'b1000;
        last = -P;
        for (int j = 0; j < snw; j++) begin
            arr = (sa[j] < 0) ? 0 : sa[j];
            kp  = (arr > last + P) ? arr : last + P;
            last = kp;
            exp_v[kp][2] = 1'b1;
            for (int t = kp; t < kp + 2 + NB * C; t++) exp_v[t][1] = 1'b1;
            exp_v[kp + 2 + NB * C][0] = 1'b1;
            for (int t = 0; t < NB * C; t++) begin
                b = t / C;
                if (b == 0)                    bitv = 1'b0;
                else if (b <= W)               bitv = sw[j][b-1];
                else if (PAR == 1 && b == W+1) bitv = ^sw[j];
                else                           bitv = 1'b1;
                exp_v[kp + 2 + t][3] = bitv;
            end
        end
        n = last + P + 4;
        n_reads = 0;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < snw; j++) if (sa[j] == k) push(sw[j]);
            @(posedge clk);
            @(negedge clk);
            obs = {tx, bus.fifo_read, busy, frame_done};
            obs_tx[k] = tx;
            obs_dn[k] = frame_done;
            if (bus.fifo_read === 1'b1) n_reads++;
            total++;
            if (obs !== exp_v[k]) begin
                bad++;
                $display("FAIL %s cyc=%0d {tx,read,busy,done} got=%b want=%b", name, k, obs, exp_v[k]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        push(4'hA);
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if ({tx, bus.fifo_read, busy, frame_done} !== 4'b1000) begin
                bad++;
                $display("FAIL reset edge=%0d got=%b want=1000", e, {tx, bus.fifo_read, busy, frame_done});
            end
        end
    endtask

    task automatic test_single_word;
        logic [5:0] pat;
        rst = 1'b1;
        sw[0] = 4'hA; sa[0] = -1; snw = 1;
        run_stream("single");
`ifndef FIFO_UART_TX_PARITY_EN
        pat = 6'b110100;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (obs_tx[2 + C*i + 1] !== pat[i]) begin
                bad++;
                $display("FAIL single_bit%0d got=%b want=%b", i, obs_tx[2 + C*i + 1], pat[i]);
            end
        end
`else
        pat = '0;
`endif
        total++;
        if (obs_dn[2 + NB*C] !== 1'b1) begin
            bad++;
            $display("FAIL single_done_at got=%b want=1", obs_dn[2 + NB*C]);
        end
    endtask

    task automatic test_three_words;
        for (int j = 0; j < 3; j++) begin sw[j] = 4'(j + 1); sa[j] = 0; end
        snw = 3;
        run_stream("three");
        total++;
        if (n_reads !== 3) begin
            bad++;
            $display("FAIL three_reads got=%0d want=3", n_reads);
        end
    endtask

    task automatic test_empty_hold;
        hold_empty = 1'b1;
        push(4'h5);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if ({tx, bus.fifo_read, busy} !== 3'b100) begin
                bad++;
                $display("FAIL empty_hold cyc=%0d {tx,read,busy} got=%b want=100", k, {tx, bus.fifo_read, busy});
            end
        end
        hold_empty = 1'b0;
        sw[0] = 4'h5; sa[0] = -1; snw = 1;
        run_stream("after_hold");
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] w, w2;
        w  = 4'($urandom);
        w2 = 4'($urandom);
        push(w);
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 14) begin
                total++;
                if ({tx, busy} !== {w[2], 1'b1}) begin
                    bad++;
                    $display("FAIL mid_bit2 {tx,busy} got=%b want=%b", {tx, busy}, {w[2], 1'b1});
                end
            end
        end
        rst = 1'b0;
        push(w2);
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({tx, bus.fifo_read, busy, frame_done} !== 4'b1000) begin
            bad++;
            $display("FAIL mid_reset got=%b want=1000", {tx, bus.fifo_read, busy, frame_done});
        end
        rst = 1'b1;
        sw[0] = w2; sa[0] = -1; snw = 1;
        run_stream("rst_recover");
    endtask

    task automatic test_random;
        for (int it = 0; it < 4; it++) begin
            snw = int'($urandom_range(1, 4));
            for (int j = 0; j < snw; j++) begin
                sw[j] = 4'($urandom);
                sa[j] = (j == 0) ? int'($urandom_range(0, 20)) : sa[j-1] + int'($urandom_range(0, 45));
            end
            run_stream("random");
        end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity;
        logic [6:0] pat;
        pat = 7'b1101110;
        sw[0] = 4'h7; sa[0] = 0; snw = 1;
        run_stream("parity");
        for (int i = 0; i < 7; i++) begin
            total++;
            if (obs_tx[2 + C*i + 1] !== pat[i]) begin
                bad++;
                $display("FAIL parity_bit%0d got=%b want=%b", i, obs_tx[2 + C*i + 1], pat[i]);
            end
        end
        total++;
        if (obs_dn[30] !== 1'b1) begin
            bad++;
            $display("FAIL parity_len done@30 got=%b want=1", obs_dn[30]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_three_words();
        test_empty_hold();
        test_reset_mid();
        test_random();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
